panel_mem_ctrl: RTL and testbench
=================================

# panel_mem_ctrl

Front-panel memory controller and RAM-port arbiter for the PDP8 core. It sits between the CPU datapath's RAM control/address/data busses, the front-panel switch and button outputs, and the single `RAM` instance. While the CPU is halted it sequences LOAD ADDRESS, DEPOSIT and EXAMINE operations against memory. At all other times it passes CPU memory traffic through unchanged.

## Interface
Parameters:
- `ADDR_W`, default 12: memory address width.
- `DATA_W`, default 12: memory word width.

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: synchronous, active-high reset.
- `running` in 1: sequencer run flag; high means the CPU owns memory.
- `cpu_oe`, `cpu_we` in 1 each: CPU RAM strobes (OR'ed control signals).
- `cpu_addr` in ADDR_W: CPU address bus.
- `cpu_din` in DATA_W: CPU write-data bus.
- `sw` in DATA_W: switch register.
- `btn_ldaddr`, `btn_dep`, `btn_exam` in 1 each: single-cycle debounced button pulses.
- `ram_dout` in DATA_W: RAM read data, valid the cycle after `ram_oe`.
- `ram_oe`, `ram_we` out 1 each: RAM strobes.
- `ram_addr` out ADDR_W: RAM address.
- `ram_din` out DATA_W: RAM write data.
- `panel_ma` out ADDR_W: panel memory-address register, driven to the display.
- `panel_mb` out DATA_W: panel memory-buffer register, holding the last deposited or examined word.
- `busy` out 1: a panel operation is in progress.
- `run_inhibit` out 1: equals `busy`; gated into the sequencer RUN input.
- `rejected` out 1: one-cycle pulse when a button press is dropped.

## Operation
- States: IDLE, DEP_WR, EX_RD, EX_CAP, INC.
- In IDLE, the `ram_*` outputs mirror the `cpu_*` inputs combinationally.
- In any other state, the `cpu_*` inputs are ignored and the controller drives the RAM port.
- Button acceptance:
  - A button is accepted only in IDLE with `running`=0.
  - Priority when buttons arrive together: `btn_ldaddr` > `btn_dep` > `btn_exam`.
  - Losing buttons in a simultaneous press are silently dropped, with no `rejected` pulse.
  - A press arriving while `running`=1 or `busy`=1 pulses `rejected` the next cycle and has no other effect.
- LOAD ADDRESS: `panel_ma` <= `sw`. The FSM stays in IDLE; no RAM cycle occurs.
- DEPOSIT:
  - IDLE to DEP_WR: `ram_we`=1, `ram_addr`=`panel_ma`, `ram_din`=`sw`.
  - `panel_mb` <= `sw` at the end of DEP_WR.
  - DEP_WR to INC.
- EXAMINE:
  - IDLE to EX_RD: `ram_oe`=1, `ram_addr`=`panel_ma`.
  - EX_RD to EX_CAP: `ram_oe` is held and `panel_mb` <= `ram_dout`.
  - EX_CAP to INC.
- INC: `panel_ma` <= `panel_ma`+1, modulo 2^ADDR_W (7777 wraps to 0000). The FSM returns to IDLE.
- `busy` is high whenever state != IDLE.
- `ram_oe` and `ram_we` are never both high.

## Timing
- Reset values: state IDLE, `panel_ma`=0, `panel_mb`=0, `busy`=0, `run_inhibit`=0, `rejected`=0.
- During reset, `ram_oe`/`ram_we` follow the CPU strobes, since IDLE pass-through applies.
- Latency after a press sampled at edge N:
  - LOAD ADDRESS: `panel_ma` is updated at N+1.
  - DEPOSIT: write cycle during N+1 to N+2; `panel_ma` increments at N+3; `busy` is low from N+3. Total 2 busy cycles.
  - EXAMINE: read cycle N+1 to N+3; `panel_mb` updated at N+3; `panel_ma` increments at N+4. Total 3 busy cycles.
- `rejected` is asserted during the cycle after the dropped press.
- `running` rising mid-operation: the operation completes. The sequencer cannot start because `run_inhibit`=1. The CPU should never assert strobes while `running`=0.
- `RESET` mid-operation: the FSM aborts to IDLE the next edge and the registers clear. A partially issued write is not repeated.
- `panel_ma` and `panel_mb` are unaffected by CPU traffic.

## Configuration
- `PANEL_AUTOINC_EN` defined:
  - DEPOSIT and EXAMINE pass through INC as described.
  - Consecutive presses step through memory.
- `PANEL_AUTOINC_EN` undefined:
  - The INC state is not built; DEP_WR and EX_CAP return directly to IDLE.
  - `panel_ma` changes only on LOAD ADDRESS or RESET.
  - Busy time: DEPOSIT 1 cycle, EXAMINE 2 cycles.

## Test plan
- Reset, then LOAD ADDRESS with `sw`=0200 -> `panel_ma`=0200 next cycle, `busy` stays 0, no RAM strobe.
- With `panel_ma`=0200: DEPOSIT `sw`=7402, then `sw`=1234 -> RAM[0200]=7402, RAM[0201]=1234, `panel_ma`=0202, `panel_mb`=1234. Each DEPOSIT shows exactly 1 `ram_we` cycle.
- LOAD ADDRESS 0200, then EXAMINE twice -> `panel_mb`=7402, then 1234. `panel_ma` ends at 0202. `busy` is high 3 cycles per press.
- LOAD ADDRESS 7777, DEPOSIT 0001 -> RAM[7777]=0001 and `panel_ma` wraps to 0000. Without the macro, `panel_ma` stays 7777.
- Press DEPOSIT with `running`=1 -> `rejected` pulses once, no `ram_we` from the panel, and `cpu_addr`/`cpu_we` pass through unchanged.
- `btn_dep` and `btn_exam` in the same cycle -> only DEPOSIT executes, no `rejected` pulse. A press during `busy` -> `rejected` pulses. RESET asserted during EX_RD -> IDLE next cycle, `panel_mb`=0.

Source files
------------

// File: rtl/panel_mem_ctrl_if.sv
// RAM-side bus of the front-panel memory controller: strobes, address and
// write data toward the RAM, read data back.
interface panel_mem_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    logic              ram_oe;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport master (
        output ram_oe,
        output ram_we,
        output ram_addr,
        output ram_din,
        input  ram_dout
    );

    modport slave (
        input  ram_oe,
        input  ram_we,
        input  ram_addr,
        input  ram_din,
        output ram_dout
    );
endinterface

// File: rtl/panel_mem_ctrl.sv
// PDP8 front-panel memory controller / RAM-port arbiter (LOAD ADDRESS, DEPOSIT, EXAMINE).
// Define PANEL_AUTOINC_EN to build the INC state that steps panel_ma after DEPOSIT/EXAMINE.
module panel_mem_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              running,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_ldaddr,
    input  logic              btn_dep,
    input  logic              btn_exam,
    panel_mem_ctrl_if.master  ram,
    output logic [ADDR_W-1:0] panel_ma,
    output logic [DATA_W-1:0] panel_mb,
    output logic              busy,
    output logic              run_inhibit,
    output logic              rejected
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DEP_WR = 3'd1,
        EX_RD  = 3'd2,
        EX_CAP = 3'd3
`ifdef PANEL_AUTOINC_EN
        ,
        INC    = 3'd4
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] panel_ma_q, panel_ma_d;
    logic [DATA_W-1:0] panel_mb_q, panel_mb_d;
    logic              rejected_q, rejected_d;

    logic any_btn;
    logic accept;

    assign any_btn = btn_ldaddr | btn_dep | btn_exam;
    assign accept  = (state_q == IDLE) && !running;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            panel_ma_q <= '0;
            panel_mb_q <= '0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            panel_ma_q <= panel_ma_d;
            panel_mb_q <= panel_mb_d;
            rejected_q <= rejected_d;
        end
    end

    // Next-state logic; LOAD ADDRESS outranks DEPOSIT, which outranks EXAMINE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !btn_ldaddr) begin
                    if (btn_dep) begin
                        state_d = DEP_WR;
                    end else if (btn_exam) begin
                        state_d = EX_RD;
                    end
                end
            end
`ifdef PANEL_AUTOINC_EN
            DEP_WR:  state_d = INC;
            EX_RD:   state_d = EX_CAP;
            EX_CAP:  state_d = INC;
            INC:     state_d = IDLE;
`else
            DEP_WR:  state_d = IDLE;
            EX_RD:   state_d = EX_CAP;
            EX_CAP:  state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Panel register updates and drop reporting
    always_comb begin
        panel_ma_d = panel_ma_q;
        panel_mb_d = panel_mb_q;
        rejected_d = any_btn && !accept;
        unique case (state_q)
            IDLE: begin
                if (accept && btn_ldaddr) begin
                    panel_ma_d = ADDR_W'(sw);
                end
            end
            DEP_WR:  panel_mb_d = sw;
            EX_CAP:  panel_mb_d = ram.ram_dout;
`ifdef PANEL_AUTOINC_EN
            INC:     panel_ma_d = panel_ma_q + 1'b1;
`endif
            default: ;
        endcase
    end

    // RAM port: CPU pass-through in IDLE, panel-driven otherwise
    always_comb begin
        ram.ram_oe   = 1'b0;
        ram.ram_we   = 1'b0;
        ram.ram_addr = panel_ma_q;
        ram.ram_din  = '0;
        unique case (state_q)
            IDLE: begin
                ram.ram_oe   = cpu_oe;
                ram.ram_we   = cpu_we;
                ram.ram_addr = cpu_addr;
                ram.ram_din  = cpu_din;
            end
            DEP_WR: begin
                ram.ram_we  = 1'b1;
                ram.ram_din = sw;
            end
            EX_RD:   ram.ram_oe = 1'b1;
            EX_CAP:  ram.ram_oe = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign run_inhibit = busy;
    assign panel_ma    = panel_ma_q;
    assign panel_mb    = panel_mb_q;
    assign rejected    = rejected_q;

endmodule

// File: tb/tb_panel_mem_ctrl.sv
// Bench for panel_mem_ctrl: directed panel sequences plus random presses,
// checked against an operation-level model of panel_ma/panel_mb/memory.
module tb_panel_mem_ctrl;

`ifdef PANEL_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        running;
    logic        cpu_oe, cpu_we;
    logic [11:0] cpu_addr, cpu_din, sw;
    logic        btn_ldaddr, btn_dep, btn_exam;
    logic [11:0] panel_ma, panel_mb;
    logic        busy, run_inhibit, rejected;

    panel_mem_ctrl_if #(.ADDR_W(12), .DATA_W(12)) ram_bus ();

    panel_mem_ctrl #(.ADDR_W(12), .DATA_W(12)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .running    (running),
        .cpu_oe     (cpu_oe),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .sw         (sw),
        .btn_ldaddr (btn_ldaddr),
        .btn_dep    (btn_dep),
        .btn_exam   (btn_exam),
        .ram        (ram_bus),
        .panel_ma   (panel_ma),
        .panel_mb   (panel_mb),
        .busy       (busy),
        .run_inhibit(run_inhibit),
        .rejected   (rejected)
    );

    always #5 CLK = ~CLK;

    // Synchronous RAM: read data appears the cycle after ram_oe
    logic [11:0] mem [0:4095] = '{default: '0};
    logic [11:0] dout_r = '0;
    assign ram_bus.ram_dout = dout_r;
    always @(posedge CLK) begin
        if (ram_bus.ram_we) mem[ram_bus.ram_addr] <= ram_bus.ram_din;
        if (ram_bus.ram_oe) dout_r <= mem[ram_bus.ram_addr];
    end

    // Reference model state
    logic [11:0] exp_mem [0:4095] = '{default: '0};
    logic [11:0] exp_ma, exp_mb;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One accepted press (mask = {ldaddr, dep, exam}) with running=0
    task automatic do_op(input logic [2:0] mask, input logic [11:0] swv);
        int busy_c, we_c, oe_c, exp_busy, exp_we, exp_oe;
        logic rej;
        logic [11:0] ma_before;
        ma_before = exp_ma;
        @(negedge CLK);
        sw = swv;
        {btn_ldaddr, btn_dep, btn_exam} = mask;
        @(negedge CLK);
        {btn_ldaddr, btn_dep, btn_exam} = 3'b000;
        rej = rejected;
        check("inhibit_eq_busy", {31'd0, run_inhibit}, {31'd0, busy});
        busy_c = 0; we_c = 0; oe_c = 0;
        for (int i = 0; i < 8; i++) begin
            if (!busy) break;
            busy_c++;
            if (ram_bus.ram_we) begin
                we_c++;
                check("dep_addr", {20'd0, ram_bus.ram_addr}, {20'd0, ma_before});
                check("dep_din", {20'd0, ram_bus.ram_din}, {20'd0, swv});
            end
            if (ram_bus.ram_oe) oe_c++;
            @(negedge CLK);
        end
        if (busy) check("busy_timeout", 32'd1, 32'd0);

        if (mask[2]) begin
            exp_ma = swv; exp_busy = 0; exp_we = 0; exp_oe = 0;
            check("ld_no_strobe", {30'd0, ram_bus.ram_we, ram_bus.ram_oe}, 32'd0);
        end else if (mask[1]) begin
            exp_mem[ma_before] = swv;
            exp_mb = swv;
            exp_busy = AUTOINC ? 2 : 1; exp_we = 1; exp_oe = 0;
            if (AUTOINC) exp_ma = exp_ma + 12'd1;
        end else begin
            exp_mb = exp_mem[ma_before];
            exp_busy = AUTOINC ? 3 : 2; exp_we = 0; exp_oe = 2;
            if (AUTOINC) exp_ma = exp_ma + 12'd1;
        end
        check("busy_cycles", busy_c, exp_busy);
        check("we_cycles", we_c, exp_we);
        check("oe_cycles", oe_c, exp_oe);
        check("panel_ma", {20'd0, panel_ma}, {20'd0, exp_ma});
        check("panel_mb", {20'd0, panel_mb}, {20'd0, exp_mb});
        check("no_reject", {31'd0, rej}, 32'd0);
        if (mask[2:1] == 2'b01) check("ram_word", {20'd0, mem[ma_before]}, {20'd0, swv});
    endtask

    // Press while running=1 alongside a CPU write
    task automatic do_reject(input logic [2:0] mask);
        logic [11:0] a, d;
        a = 12'($urandom);
        d = 12'($urandom);
        @(negedge CLK);
        running = 1'b1;
        cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        {btn_ldaddr, btn_dep, btn_exam} = mask;
        #1;
        check("pass_we", {31'd0, ram_bus.ram_we}, 32'd1);
        check("pass_addr", {20'd0, ram_bus.ram_addr}, {20'd0, a});
        check("pass_din", {20'd0, ram_bus.ram_din}, {20'd0, d});
        @(negedge CLK);
        {btn_ldaddr, btn_dep, btn_exam} = 3'b000;
        cpu_we = 1'b0;
        exp_mem[a] = d;
        check("rejected_pulse", {31'd0, rejected}, 32'd1);
        check("rej_not_busy", {31'd0, busy}, 32'd0);
        @(negedge CLK);
        check("rejected_once", {31'd0, rejected}, 32'd0);
        check("cpu_write", {20'd0, mem[a]}, {20'd0, d});
        check("ma_after_cpu", {20'd0, panel_ma}, {20'd0, exp_ma});
        check("mb_after_cpu", {20'd0, panel_mb}, {20'd0, exp_mb});
        running = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; running = 1'b0;
        cpu_oe = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; sw = '0;
        btn_ldaddr = 1'b0; btn_dep = 1'b0; btn_exam = 1'b0;
        exp_ma = '0; exp_mb = '0;
        repeat (3) @(negedge CLK);
        check("reset_oe_pass", {31'd0, ram_bus.ram_oe}, 32'd1);
        check("reset_ma", {20'd0, panel_ma}, 32'd0);
        check("reset_mb", {20'd0, panel_mb}, 32'd0);
        check("reset_flags", {29'd0, busy, run_inhibit, rejected}, 32'd0);
        cpu_oe = 1'b0;
        RESET = 1'b0;

        do_op(3'b100, 12'o0200);
        do_op(3'b010, 12'o7402);
        do_op(3'b010, 12'o1234);
        do_op(3'b100, 12'o0200);
        do_op(3'b001, 12'o0000);
        do_op(3'b001, 12'o0000);
        do_op(3'b100, 12'o7777);
        do_op(3'b010, 12'o0001);
        do_reject(3'b010);
        do_op(3'b011, 12'o4321);

        // Press during busy is dropped; the examine still completes
        exp_ma = 12'o0200;
        do_op(3'b100, 12'o0200);
        @(negedge CLK);
        btn_exam = 1'b1;
        @(negedge CLK);
        btn_exam = 1'b0;
        btn_dep = 1'b1;
        @(negedge CLK);
        btn_dep = 1'b0;
        check("busy_reject", {31'd0, rejected}, 32'd1);
        repeat (4) @(negedge CLK);
        check("busy_rej_mb", {20'd0, panel_mb}, {20'd0, exp_mem[12'o0200]});
        exp_mb = exp_mem[12'o0200];
        if (AUTOINC) exp_ma = exp_ma + 12'd1;
        check("busy_rej_ma", {20'd0, panel_ma}, {20'd0, exp_ma});
        check("busy_rej_mem", {20'd0, mem[exp_ma]}, {20'd0, exp_mem[exp_ma]});

        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2)       do_op(3'b100, ($urandom_range(0, 3) == 0) ? 12'o7777 : 12'($urandom));
            else if (r < 5)  do_op(3'b010, 12'($urandom));
            else if (r < 8)  do_op(3'b001, 12'($urandom));
            else if (r == 8) do_reject(3'($urandom_range(1, 7)));
            else             do_op(3'($urandom_range(3, 7)), 12'($urandom));
        end

        // Reset during EX_RD aborts and clears the panel registers
        @(negedge CLK);
        btn_exam = 1'b1;
        @(negedge CLK);
        btn_exam = 1'b0;
        check("exrd_busy", {31'd0, busy}, 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("abort_ma", {20'd0, panel_ma}, 32'd0);
        check("abort_mb", {20'd0, panel_mb}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
